// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//   Shares one 8-digit seven-segment display between NUM_SRC 32-bit requesters.
//   Round-robin arbitration holds each grant for DWELL_CYCLES clocks. A switch-driven
//   force override pins the display to one source. An independent scan engine walks
//   an active-low digit select and presents the matching hex nibble of show_info.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous reset, active low
//     req        in   [NUM_SRC]     level-sensitive request per source
//     src_data   in   [NUM_SRC*32]  source i value at [32*i+31:32*i]
//     force_en   in   override enable
//     force_sel  in   [SEL_W]       forced source index
//     gnt        out  [NUM_SRC]     one-hot grant, zero when idle
//     show_info  out  [32]          value currently displayed
//     sel_seg    out  [8]           digit select, active-low one-hot
//     digit      out  [4]           hex nibble for the selected digit
//
//   Build option SEG_SCHED_FREEZE_EN: show_info is captured once per grant
//   (and in FORCE only when force_sel changes) instead of tracking src_data live.
module seg_display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int SEL_W        = 3,
    parameter int DWELL_CYCLES = 50000000,
    parameter int SCAN_DIV     = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [NUM_SRC*32-1:0]  src_data,
    input  logic                   force_en,
    input  logic [SEL_W-1:0]       force_sel,
    output logic [NUM_SRC-1:0]     gnt,
    output logic [31:0]            show_info,
    output logic [7:0]             sel_seg,
    output logic [3:0]             digit
);
    localparam int PTR_W   = $clog2(NUM_SRC);
    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam int SCAN_W  = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_e;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } arb_t;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic [31:0]          show_q, show_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [7:0]           sel_q, sel_d;
    logic [3:0]           digit_q, digit_d;
`ifdef SEG_SCHED_FREEZE_EN
    logic [SEL_W-1:0]     fsel_q, fsel_d;
`endif

    logic [31:0] src_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_arr[i] = src_data[32*i +: 32];
    end

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_SRC - 1) ? '0 : i + 1'b1;
    endfunction

    // First requester found scanning start, start+1, ... modulo NUM_SRC.
    function automatic arb_t arbitrate(input logic [NUM_SRC-1:0] r,
                                       input logic [PTR_W-1:0]   start);
        arb_t             res;
        logic [PTR_W-1:0] p;
        res = '0;
        p   = start;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!res.found && r[p]) begin
                res.found = 1'b1;
                res.idx   = p;
            end
            p = next_idx(p);
        end
        return res;
    endfunction

    arb_t             arb_idle, arb_exp;
    logic             expire, released, force_ok, force_load, hold_load;
    logic [PTR_W-1:0] force_idx;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        show_d   = show_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        dwell_d  = dwell_q;

        arb_idle  = arbitrate(req, rr_ptr_q);
        arb_exp   = arbitrate(req, next_idx(gidx_q));
        expire    = (state_q == HOLD) && (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
        released  = (state_q == HOLD) && !req[gidx_q];
        force_ok  = int'(force_sel) < NUM_SRC;
        force_idx = PTR_W'(force_sel);
`ifdef SEG_SCHED_FREEZE_EN
        fsel_d     = force_en ? force_sel : fsel_q;
        force_load = (state_q != FORCE) || (force_sel != fsel_q);
        hold_load  = 1'b0;
`else
        force_load = 1'b1;
        hold_load  = 1'b1;
`endif

        if (force_en) begin
            // Override beats everything, but a grant ending on this edge still advances the pointer.
            state_d = FORCE;
            dwell_d = '0;
            if (expire || released) rr_ptr_d = next_idx(gidx_q);
            if (force_ok) begin
                gnt_d  = NUM_SRC'(1) << force_idx;
                gidx_d = force_idx;
                if (force_load) show_d = src_arr[force_idx];
            end else begin
                gnt_d  = '0;
                show_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    dwell_d = '0;
                    if (arb_idle.found) begin
                        state_d = HOLD;
                        gnt_d   = NUM_SRC'(1) << arb_idle.idx;
                        gidx_d  = arb_idle.idx;
                        show_d  = src_arr[arb_idle.idx];
                    end else begin
                        gnt_d  = '0;
                        show_d = '0;
                    end
                end
                HOLD: begin
                    if (released) begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        show_d   = '0;
                        dwell_d  = '0;
                        rr_ptr_d = next_idx(gidx_q);
                    end else if (expire) begin
                        rr_ptr_d = next_idx(gidx_q);
                        dwell_d  = '0;
                        // Back-to-back re-grant, no idle cycle in between.
                        if (arb_exp.found) begin
                            gnt_d  = NUM_SRC'(1) << arb_exp.idx;
                            gidx_d = arb_exp.idx;
                            show_d = src_arr[arb_exp.idx];
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            show_d  = '0;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                        if (hold_load) show_d = src_arr[gidx_q];
                    end
                end
                FORCE: begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    show_d   = '0;
                    dwell_d  = '0;
                    rr_ptr_d = PTR_W'((int'(force_sel) + 1) % NUM_SRC);
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    show_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        scan_d  = scan_q;
        sel_d   = sel_q;
        digit_d = digit_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            // A corrupted select pattern recovers to digit 0 instead of propagating.
            if ($countones(~sel_q) == 1) sel_d = {sel_q[6:0], sel_q[7]};
            else                         sel_d = 8'hFE;
            digit_d = '0;
            for (int j = 0; j < 8; j++) begin
                if (!sel_d[j]) digit_d = show_q[4*j +: 4];
            end
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            show_q   <= '0;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            dwell_q  <= '0;
            scan_q   <= '0;
            sel_q    <= 8'hFE;
            digit_q  <= '0;
`ifdef SEG_SCHED_FREEZE_EN
            fsel_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            show_q   <= show_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            dwell_q  <= dwell_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            digit_q  <= digit_d;
`ifdef SEG_SCHED_FREEZE_EN
            fsel_q   <= fsel_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign show_info = show_q;
    assign sel_seg   = sel_q;
    assign digit     = digit_q;

endmodule
